// File: rtl/imm_extend_pipe_pkg.sv
// Shared encodings for the immediate-extension pipeline: extension modes
// and the skid-buffer occupancy states.
package imm_extend_pipe_pkg;

    localparam int MODE_W  = 2;
    localparam int STATE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_SEXT  = 2'b00,
        MODE_ZEXT  = 2'b01,
        MODE_BOFF  = 2'b10,
        MODE_UPPER = 2'b11
    } mode_e;

    typedef enum logic [STATE_W-1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

endpackage : imm_extend_pipe_pkg

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: sign/zero extend, branch offset
// (sign-extended, shifted left by one) and upper-immediate placement.
module imm_ext_core
    import imm_extend_pipe_pkg::*;
#(
    parameter int IN_W  = 12,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]   i_a,
    input  logic [MODE_W-1:0] i_mode,
    output logic [OUT_W-1:0]  o_r
);

    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_zext;
    logic [OUT_W-1:0] w_boff;
    logic [OUT_W-1:0] w_upper;

    // Size casts avoid a zero-width replication when IN_W == OUT_W.
    assign w_sext  = OUT_W'($signed(i_a));
    assign w_zext  = OUT_W'(i_a);
    assign w_boff  = {w_sext[OUT_W-2:0], 1'b0};
    assign w_upper = w_zext << (OUT_W - IN_W);

    // NOTE: every output of a combinational block gets a default first, so no latch can be inferred.
    always_comb begin
        o_r = w_sext;
        case (i_mode)
            MODE_SEXT:  o_r = w_sext;
            MODE_ZEXT:  o_r = w_zext;
            MODE_BOFF:  o_r = w_boff;
            MODE_UPPER: o_r = w_upper;
            default:    o_r = w_sext;
        endcase
    end

endmodule : imm_ext_core

// File: rtl/imm_extend_pipe.sv
// Immediate extender behind a 2-entry skid FIFO: one-cycle latency,
// full throughput, registered result, ready independent of R_ready.
module imm_extend_pipe
    import imm_extend_pipe_pkg::*;
#(
    parameter int IN_W  = 12,
    parameter int OUT_W = 16
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [IN_W-1:0]   A,
    input  logic [MODE_W-1:0] MODE,
    input  logic              A_valid,
    output logic              A_ready,
    output logic [OUT_W-1:0]  R,
    output logic              R_valid,
    input  logic              R_ready
);

    state_e           r_state;
    state_e           w_state_next;
    logic [OUT_W-1:0] r_head;
    logic [OUT_W-1:0] r_tail;
    logic [OUT_W-1:0] w_ext;
    logic             w_a_ready;
    logic             w_r_valid;
    logic             w_push;
    logic             w_pop;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .i_a    (A),
        .i_mode (MODE),
        .o_r    (w_ext)
    );

    assign w_push = A_valid & w_a_ready;
    assign w_pop  = w_r_valid & R_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (Reset) r_state <= ST_EMPTY;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: if (w_push) w_state_next = ST_ONE;
            ST_ONE: begin
                if (w_push && !w_pop)      w_state_next = ST_TWO;
                else if (!w_push && w_pop) w_state_next = ST_EMPTY;
            end
            ST_TWO:   if (w_pop) w_state_next = ST_ONE;
            default:  w_state_next = ST_EMPTY;
        endcase
    end

    // Handshake flags come from the state alone; R_ready never reaches A_ready.
    always_comb begin
        w_a_ready = (r_state != ST_TWO);
        w_r_valid = (r_state != ST_EMPTY);
    end

    assign A_ready = w_a_ready;
    assign R_valid = w_r_valid;

    // Head register drives R directly; it is the only storage with a defined reset value.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_head <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_push) r_head <= w_ext;
                ST_ONE:   if (w_push && w_pop) r_head <= w_ext;
                ST_TWO:   if (w_pop) r_head <= r_tail;
                default:  r_head <= r_head;
            endcase
        end
    end

    // NOTE: the skid entry is not reset; it is only read after being written in state ONE.
    always_ff @(posedge CLK) begin
        if (r_state == ST_ONE && w_push && !w_pop) r_tail <= w_ext;
    end

    assign R = r_head;

endmodule : imm_extend_pipe

// File: tb/tb_imm_extend_pipe.sv
// Directed and randomised checks of imm_extend_pipe at default widths and
// at IN_W=8 / OUT_W=32.
module tb_imm_extend_pipe;

    logic        CLK = 1'b0;
    logic        Reset;

    logic [11:0] A;
    logic [1:0]  MODE;
    logic        A_valid;
    logic        A_ready;
    logic [15:0] R;
    logic        R_valid;
    logic        R_ready;

    logic [7:0]  A2;
    logic [1:0]  MODE2;
    logic        A2_valid;
    logic        A2_ready;
    logic [31:0] R2;
    logic        R2_valid;
    logic        R2_ready;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    imm_extend_pipe dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .A       (A),
        .MODE    (MODE),
        .A_valid (A_valid),
        .A_ready (A_ready),
        .R       (R),
        .R_valid (R_valid),
        .R_ready (R_ready)
    );

    imm_extend_pipe #(.IN_W(8), .OUT_W(32)) dut_w (
        .CLK     (CLK),
        .Reset   (Reset),
        .A       (A2),
        .MODE    (MODE2),
        .A_valid (A2_valid),
        .A_ready (A2_ready),
        .R       (R2),
        .R_valid (R2_valid),
        .R_ready (R2_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [15:0] ref_ext(input logic [11:0] a, input logic [1:0] m);
        logic [15:0] s;
        s = {{4{a[11]}}, a};
        case (m)
            2'b00:   return s;
            2'b01:   return {4'h0, a};
            2'b10:   return {s[14:0], 1'b0};
            default: return {a, 4'h0};
        endcase
    endfunction

    logic [15:0] q[$];
    logic        pend;
    logic        exp_ready;
    logic        exp_valid;
    logic        do_push;
    logic        do_pop;

    initial begin
        Reset = 1'b1; A = '0; MODE = '0; A_valid = 1'b0; R_ready = 1'b1;
        A2 = '0; MODE2 = '0; A2_valid = 1'b0; R2_ready = 1'b1;
        tick(); tick();
        check("rst_r_valid", 32'(R_valid), 32'h0);
        check("rst_a_ready", 32'(A_ready), 32'h1);
        check("rst_r",       32'(R),       32'h0);

        // Four modes back to back on A=888h, one cycle latency
        Reset = 1'b0;
        A = 12'h888; MODE = 2'b00; A_valid = 1'b1;
        tick(); check("m_sext", 32'(R), 32'hF888); check("m_sext_v", 32'(R_valid), 32'h1);
        MODE = 2'b01;
        tick(); check("m_zext", 32'(R), 32'h0888);
        MODE = 2'b10;
        tick(); check("m_boff", 32'(R), 32'hF110);
        MODE = 2'b11;
        tick(); check("m_upper", 32'(R), 32'h8880); check("m_ready", 32'(A_ready), 32'h1);
        A_valid = 1'b0;
        tick(); check("drain_v", 32'(R_valid), 32'h0);

        // Boundary immediates
        A_valid = 1'b1;
        A = 12'h000; MODE = 2'b00; tick(); check("b_zero",  32'(R), 32'h0000);
        A = 12'hFFF; MODE = 2'b00; tick(); check("b_ones",  32'(R), 32'hFFFF);
        A = 12'h3FF; MODE = 2'b00; tick(); check("b_3ff",   32'(R), 32'h03FF);
        A = 12'h7FF; MODE = 2'b10; tick(); check("b_boff+", 32'(R), 32'h0FFE);
        A = 12'h800; MODE = 2'b10; tick(); check("b_boff-", 32'(R), 32'hF000);
        A_valid = 1'b0;
        tick(); check("b_drain", 32'(R_valid), 32'h0);

        // Back-pressure: three offers, two accepted, R held stable
        R_ready = 1'b0; A_valid = 1'b1; MODE = 2'b01;
        A = 12'h001; tick();
        check("bp_one_r", 32'(R), 32'h0001); check("bp_one_rdy", 32'(A_ready), 32'h1);
        A = 12'h002; tick();
        check("bp_two_rdy", 32'(A_ready), 32'h0); check("bp_two_r", 32'(R), 32'h0001);
        A = 12'h003; tick();
        check("bp_hold_rdy", 32'(A_ready), 32'h0); check("bp_hold_r", 32'(R), 32'h0001);
        tick();
        check("bp_hold2_r", 32'(R), 32'h0001); check("bp_hold2_v", 32'(R_valid), 32'h1);
        R_ready = 1'b1; tick();
        check("bp_pop1", 32'(R), 32'h0002); check("bp_pop1_rdy", 32'(A_ready), 32'h1);
        tick();
        check("bp_pop2", 32'(R), 32'h0003);
        A_valid = 1'b0; tick();
        check("bp_empty", 32'(R_valid), 32'h0);

        // Reset while full with an offer pending
        R_ready = 1'b0; A_valid = 1'b1; MODE = 2'b01;
        A = 12'h0AA; tick();
        A = 12'h0BB; tick();
        check("rf_full", 32'(A_ready), 32'h0);
        A = 12'h0CC; Reset = 1'b1; tick();
        check("rf_v",   32'(R_valid), 32'h0);
        check("rf_rdy", 32'(A_ready), 32'h1);
        check("rf_r",   32'(R),       32'h0);
        Reset = 1'b0; R_ready = 1'b1; A = 12'h123; tick();
        check("rf_first",   32'(R),       32'h0123);
        check("rf_first_v", 32'(R_valid), 32'h1);
        A_valid = 1'b0; tick();
        check("rf_after", 32'(R_valid), 32'h0);

        // Wide instance: IN_W=8, OUT_W=32
        A2_valid = 1'b1; A2 = 8'h80;
        MODE2 = 2'b00; tick(); check("w_sext",  R2, 32'hFFFF_FF80);
        MODE2 = 2'b11; tick(); check("w_upper", R2, 32'h8000_0000);
        MODE2 = 2'b01; tick(); check("w_zext",  R2, 32'h0000_0080);
        MODE2 = 2'b10; tick(); check("w_boff",  R2, 32'hFFFF_FF00);
        A2_valid = 1'b0; tick(); check("w_drain", 32'(R2_valid), 32'h0);

        // Random traffic against a queue model
        q.delete();
        pend = 1'b0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (!pend) begin
                A_valid = ($urandom_range(0, 3) != 0);
                A       = 12'($urandom);
                MODE    = 2'($urandom);
            end
            R_ready   = ($urandom_range(0, 3) != 0);
            exp_ready = (q.size() < 2);
            exp_valid = (q.size() != 0);
            check("rnd_a_ready", 32'(A_ready), 32'(exp_ready));
            check("rnd_r_valid", 32'(R_valid), 32'(exp_valid));
            if (exp_valid) check("rnd_r", 32'(R), 32'(q[0]));
            do_push = A_valid && exp_ready;
            do_pop  = exp_valid && R_ready;
            pend    = A_valid && !exp_ready;
            tick();
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(ref_ext(A, MODE));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_imm_extend_pipe

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 Parameter IN_W, default 12, immediate field width; SHALL satisfy 2 <= IN_W <= OUT_W.
REQ-002 Parameter OUT_W, default 16, datapath word width.
REQ-003 Port CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 Port Reset  input  1  synchronous, active-high reset.
REQ-005 Port A  input  IN_W  immediate field to extend.
REQ-006 Port MODE  input  2  extension mode; sampled together with A.
REQ-007 Port A_valid  input  1  producer offers A/MODE this cycle.
REQ-008 Port A_ready  output  1  block accepts A/MODE this cycle.
REQ-009 Port R  output  OUT_W  extended result.
REQ-010 Port R_valid  output  1  R holds a valid result.
REQ-011 Port R_ready  input  1  consumer takes R this cycle.

Function
REQ-012 Input transfer SHALL occur on a rising edge where A_valid and A_ready are both 1; output transfer SHALL occur where R_valid and R_ready are both 1.
REQ-013 MODE 00 (SEXT): R = A sign-extended from bit IN_W-1 to OUT_W.
REQ-014 MODE 01 (ZEXT): R = A zero-extended to OUT_W.
REQ-015 MODE 10 (BOFF): R = SEXT(A) shifted left 1, bit 0 = 0, MSB shifted out discarded.
REQ-016 MODE 11 (UPPER): R = A in bits OUT_W-1..OUT_W-IN_W, remaining low bits 0.
REQ-017 Extension SHALL be computed combinationally on input and stored; R SHALL be driven from a register, no combinational path from A/MODE to R.
REQ-018 Latency SHALL be exactly 1 cycle: an item accepted at edge N appears with R_valid=1 after edge N.
REQ-019 Storage SHALL be a 2-entry skid FIFO, state machine EMPTY / ONE / TWO.
REQ-020 A_ready SHALL be 1 in EMPTY and ONE, 0 in TWO, and SHALL depend on state only, never on R_ready.
REQ-021 R_valid SHALL be 1 in ONE and TWO, 0 in EMPTY.
REQ-022 Transitions: EMPTY+push -> ONE; ONE+push+pop -> ONE; ONE+push -> TWO; ONE+pop -> EMPTY; TWO+pop -> ONE; otherwise hold.
REQ-023 Throughput SHALL be one item per cycle when R_ready is held 1.
REQ-024 Items SHALL leave in acceptance order; no item SHALL be dropped or duplicated.
REQ-025 While R_valid=1 and R_ready=0, R SHALL remain stable.
REQ-026 A_valid in TWO SHALL be ignored; the producer holds A/MODE until accepted.
REQ-027 Simultaneous push and pop in ONE: the popped entry leaves and the new entry becomes head next cycle.

Reset
REQ-028 Reset=1 at an edge SHALL force state EMPTY, R_valid=0, A_ready=1, R=0, regardless of traffic.
REQ-029 Items held or offered during reset SHALL be discarded; first transfer is possible at the first edge with Reset=0.

Structure
REQ-030 A shared package SHALL hold the MODE encodings (SEXT, ZEXT, BOFF, UPPER) and the state encodings (EMPTY, ONE, TWO).
REQ-031 One sub-module SHALL exist: imm_ext_core, purely combinational, parametrised IN_W/OUT_W, implementing REQ-013..016.
REQ-032 imm_extend_pipe SHALL contain only the skid FIFO, state machine and one imm_ext_core instance.

Verification
REQ-033 Defaults, R_ready=1: A=888h with MODE 00/01/10/11 on consecutive cycles -> R = F888h, 0888h, F110h, 8880h on consecutive cycles, latency 1.
REQ-034 Defaults: A=000h MODE 00 -> 0000h; FFFh MODE 00 -> FFFFh; 3FFh MODE 00 -> 03FFh; 7FFh MODE 10 -> 0FFEh.
REQ-035 R_ready=0, A_valid=1 with 3 items -> 2 accepted, A_ready=0 in TWO, R stable; R_ready=1 -> all 3 out in order, no loss.
REQ-036 Reset asserted in TWO -> next cycle R_valid=0, A_ready=1, R=0; subsequent item emerges 1 cycle after acceptance.
REQ-037 IN_W=8, OUT_W=32: A=80h MODE 00 -> FFFFFF80h; MODE 11 -> 80000000h.
REQ-038 Randomised A/MODE/A_valid/R_ready over 1000 cycles vs reference model -> no mismatch, loss or reorder.
